// File: rtl/counter_run_ctrl_if.sv
// Bundle for the counter_run_ctrl control and status signals.
//   run_stop : one-cycle pulse, toggles RUN/PAUSE
//   clear    : one-cycle pulse, back to IDLE with count 0
//   dir      : 0 = count up, 1 = count down
//   count    : current count, 0..MAX
//   running  : high while the controller is in RUN
//   tick     : one-cycle pulse with every count update
//   wrap     : one-cycle pulse with a wrapping count update
// master drives the buttons and direction; slave is the controller.
interface counter_run_ctrl_if;
  logic        run_stop;
  logic        clear;
  logic        dir;
  logic [13:0] count;
  logic        running;
  logic        tick;
  logic        wrap;

  modport master (
    output run_stop, clear, dir,
    input  count, running, tick, wrap
  );

  modport slave (
    input  run_stop, clear, dir,
    output count, running, tick, wrap
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run/pause/clear controller and tick scheduler for a 0..MAX counter.
// A prescaler in the clk domain produces a single-cycle internal tick every
// DIV = CLK_HZ/TICK_HZ cycles while running; each tick steps the count up or
// down with wrap-around.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : counter_run_ctrl_if.slave (run_stop, clear, dir in;
//         count, running, tick, wrap out)
//
// state | meaning
// IDLE  | stopped, count and prescaler held at 0
// RUN   | prescaler advancing, count steps on every internal tick
// PAUSE | prescaler and count frozen, phase kept for resume
module counter_run_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int MAX     = 9999
) (
  input  logic              clk,
  input  logic              rst,
  counter_run_ctrl_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [13:0]   COUNT_MAX  = 14'(MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [13:0]   count_q;
  logic          running_q;
  logic          tick_q;
  logic          wrap_q;

  logic          tick_int;
  logic [13:0]   count_next;
  logic          wrap_next;

  assign tick_int = (state == RUN) && (presc == PRESC_LAST);

  // Value the count takes on a tick; dir is only meaningful on that cycle.
  always_comb begin
    count_next = count_q;
    wrap_next  = 1'b0;
    if (bus.dir) begin
      if (count_q == 14'd0) begin
        count_next = COUNT_MAX;
        wrap_next  = 1'b1;
      end else begin
        count_next = count_q - 14'd1;
      end
    end else begin
      if (count_q >= COUNT_MAX) begin
        count_next = 14'd0;
        wrap_next  = 1'b1;
      end else begin
        count_next = count_q + 14'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.clear) begin
        // Clear outranks both run_stop and a coincident tick.
        state     <= IDLE;
        presc     <= '0;
        count_q   <= '0;
        running_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (bus.run_stop) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (tick_int) begin
              presc   <= '0;
              count_q <= count_next;
              tick_q  <= 1'b1;
              wrap_q  <= wrap_next;
            end else begin
              presc <= presc + 1'b1;
            end
            // A stop on a tick cycle still lets that tick land.
            if (bus.run_stop) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end
          end
          PAUSE: begin
            if (bus.run_stop) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            presc     <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
module tb_counter_run_ctrl;
  localparam int DIV = 10;
  localparam int MAX = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   started = 1'b0;

  typedef struct {
    int cyc;
    int count;
    int wrap;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int m_count   = 0;
  int m_running = 0;
  int m_phase   = 0;

  counter_run_ctrl_if bus ();

  counter_run_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .MAX(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Predict what the coming clock edge does; ticks go to the scoreboard.
  task automatic model_edge(input bit rs, input bit clr);
    exp_t e;
    if (clr) begin
      m_running = 0;
      m_phase   = 0;
      m_count   = 0;
    end else begin
      if (m_running != 0) begin
        if (m_phase == DIV - 1) begin
          m_phase = 0;
          e.wrap  = 0;
          if (bus.dir) begin
            if (m_count == 0) begin m_count = MAX; e.wrap = 1; end
            else m_count = m_count - 1;
          end else begin
            if (m_count == MAX) begin m_count = 0; e.wrap = 1; end
            else m_count = m_count + 1;
          end
          e.cyc   = cyc + 1;
          e.count = m_count;
          sb.push_back(e);
        end else begin
          m_phase = m_phase + 1;
        end
      end
      if (rs) m_running = (m_running != 0) ? 0 : 1;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit rs, input bit clr);
    bus.run_stop = rs;
    bus.clear    = clr;
    model_edge(rs, clr);
    @(posedge clk);
    @(negedge clk);
    bus.run_stop = 1'b0;
    bus.clear    = 1'b0;
    chk("count", int'(bus.count), m_count);
    chk("running", int'(bus.running), m_running);
    chk("range", int'(bus.count <= 14'(MAX)), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  // Scoreboard: every DUT tick must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && started) begin
      if (bus.tick) begin
        if (sb.size() == 0) begin
          chk("spurious_tick", int'(bus.tick), 0);
        end else begin
          e = sb.pop_front();
          chk("tick_cycle", cyc, e.cyc);
          chk("tick_count", int'(bus.count), e.count);
          chk("tick_wrap", int'(bus.wrap), e.wrap);
        end
      end else begin
        chk("stray_wrap", int'(bus.wrap), 0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          void'(sb.pop_front());
          chk("missed_tick", int'(bus.tick), 1);
        end
      end
    end
  end

  initial begin
    int saved;
    int k;
    bit hit;
    bus.run_stop = 1'b0;
    bus.clear    = 1'b0;
    bus.dir      = 1'b0;

    // Reset held for 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    rst = 1'b0;
    started = 1'b1;
    idle(50);

    // Count up: ticks at +10, +20, +30
    cycle(1'b1, 1'b0);
    idle(35);
    chk("up3_count", int'(bus.count), 3);

    // Up through MAX to 0 with wrap (tick at +100)
    idle(70);
    chk("wrap_up_count", int'(bus.count), 0);

    // Down from 0 wraps to MAX
    bus.dir = 1'b1;
    idle(5);
    chk("wrap_dn_count", int'(bus.count), MAX);
    bus.dir = 1'b0;

    // Pause 4 cycles into a period, resume, next tick 6 cycles later
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.tick) hit = 1;
    end
    chk("find_tick", int'(hit), 1);
    idle(3);
    cycle(1'b1, 1'b0);
    chk("paused_running", int'(bus.running), 0);
    saved = int'(bus.count);
    idle(50);
    chk("pause_hold", int'(bus.count), saved);
    cycle(1'b1, 1'b0);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      cycle(1'b0, 1'b0);
      if (bus.tick) k = i;
    end
    chk("resume_latency", k, 6);

    // Clear and run_stop together while running at count 5
    for (int i = 0; i < 150 && int'(bus.count) != 5; i++) cycle(1'b0, 1'b0);
    chk("reach5", int'(bus.count), 5);
    cycle(1'b1, 1'b1);
    chk("clr_rs_count", int'(bus.count), 0);
    chk("clr_rs_running", int'(bus.running), 0);
    idle(30);

    // Clear landing on a tick cycle
    cycle(1'b1, 1'b0);
    idle(9);
    cycle(1'b0, 1'b1);
    chk("clr_tick_tick", int'(bus.tick), 0);
    chk("clr_tick_count", int'(bus.count), 0);
    idle(20);

    // Stop landing on a tick cycle: tick applied, then paused
    cycle(1'b1, 1'b0);
    idle(9);
    cycle(1'b1, 1'b0);
    chk("rs_tick_tick", int'(bus.tick), 1);
    chk("rs_tick_count", int'(bus.count), 1);
    chk("rs_tick_running", int'(bus.running), 0);
    idle(30);

    // Asynchronous reset mid-period at count 7
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 150 && int'(bus.count) != 7; i++) cycle(1'b0, 1'b0);
    chk("reach7", int'(bus.count), 7);
    idle(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_running", int'(bus.running), 0);
    chk("async_rst_tick", int'(bus.tick), 0);
    m_count   = 0;
    m_running = 0;
    m_phase   = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(50);
    chk("post_rst_running", int'(bus.running), 0);
    chk("post_rst_count", int'(bus.count), 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
